// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   clog2    : ceiling log2, usable in constant expressions.
//   width_ok : legal WIDTH/GROUP combination (GROUP >= 2, WIDTH a
//              non-zero multiple of GROUP); checked at elaboration.
package cla_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit width_ok(input int width, input int group);
    return (group >= 2) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead unit.
//   p, g : per-bit propagate / generate
//   ci   : carry into the group
//   gp   : group propagate (all bits propagate)
//   gg   : group generate (carry leaves the group regardless of ci)
//   s    : GROUP-bit sum, p ^ internal carries
// Every internal carry is built as a flat sum of products of p/g/ci,
// so no carry depends on a neighbouring carry.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             ci,
  output logic             gp,
  output logic             gg,
  output logic [GROUP-1:0] s
);

  logic [GROUP-1:0] c;
  logic             prod;
  logic             gg_acc;

  always_comb begin
    c      = '0;
    prod   = 1'b0;
    gg_acc = 1'b0;
    c[0]   = ci;
    for (int i = 1; i < GROUP; i++) begin
      for (int j = 0; j < i; j++) begin
        prod = g[j];
        for (int k = j + 1; k < i; k++) prod = prod & p[k];
        c[i] = c[i] | prod;
      end
      prod = ci;
      for (int k = 0; k < i; k++) prod = prod & p[k];
      c[i] = c[i] | prod;
    end
    for (int j = 0; j < GROUP; j++) begin
      prod = g[j];
      for (int k = j + 1; k < GROUP; k++) prod = prod & p[k];
      gg_acc = gg_acc | prod;
    end
  end

  assign gp = &p;
  assign gg = gg_acc;
  assign s  = p ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with a
// valid/ready stream interface and a single global stall.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready = pipeline enable)
//   a, b, cin, sub      : operands; sub=1 computes a + ~b + 1, cin ignored
//   out_valid/out_ready : result handshake
//   sum, cout, overflow : result, carry out of MSB, signed overflow
// Stage 1 registers per-bit p/g and per-group P/G; stage 2 resolves
// the group carries by lookahead and forms the sums.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NG = WIDTH / GROUP;

  if (!width_ok(WIDTH, GROUP)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and GROUP >= 2");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_s1;
  logic [WIDTH-1:0] g_s1;
  logic [NG-1:0]    gp_s1;
  logic [NG-1:0]    gg_s1;
  logic [WIDTH-1:0] s1_sum_unused;

  logic [WIDTH-1:0] p_d, p_q, g_d, g_q;
  logic [NG-1:0]    gp_d, gp_q, gg_d, gg_q;
  logic             c0_d, c0_q;
  logic             s1_valid_d, s1_valid_q;

  logic [NG:0]      c_grp;
  logic             prod;
  logic [WIDTH-1:0] sum_s2;
  logic [NG-1:0]    s2_gp_unused;
  logic [NG-1:0]    s2_gg_unused;
  logic             c_msb_in;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             overflow_d, overflow_q;
  logic             out_valid_d, out_valid_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  assign b_eff = sub ? ~b : b;
  assign p_s1  = a ^ b_eff;
  assign g_s1  = a & b_eff;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    // Stage-1 instance only supplies group P/G; its sum is meaningless.
    cla_group #(.GROUP(GROUP)) u_pg (
      .p  (p_s1[gi*GROUP +: GROUP]),
      .g  (g_s1[gi*GROUP +: GROUP]),
      .ci (1'b0),
      .gp (gp_s1[gi]),
      .gg (gg_s1[gi]),
      .s  (s1_sum_unused[gi*GROUP +: GROUP])
    );
    cla_group #(.GROUP(GROUP)) u_sum (
      .p  (p_q[gi*GROUP +: GROUP]),
      .g  (g_q[gi*GROUP +: GROUP]),
      .ci (c_grp[gi]),
      .gp (s2_gp_unused[gi]),
      .gg (s2_gg_unused[gi]),
      .s  (sum_s2[gi*GROUP +: GROUP])
    );
  end

  // Group carry-ins as flat products of registered P/G and c0.
  always_comb begin
    c_grp    = '0;
    prod     = 1'b0;
    c_grp[0] = c0_q;
    for (int i = 1; i <= NG; i++) begin
      for (int j = 0; j < i; j++) begin
        prod = gg_q[j];
        for (int k = j + 1; k < i; k++) prod = prod & gp_q[k];
        c_grp[i] = c_grp[i] | prod;
      end
      prod = c0_q;
      for (int k = 0; k < i; k++) prod = prod & gp_q[k];
      c_grp[i] = c_grp[i] | prod;
    end
  end

  // sum = p ^ carry, so the carry into the MSB falls out of the MSB sum.
  assign c_msb_in = sum_s2[WIDTH-1] ^ p_q[WIDTH-1];

  always_comb begin
    p_d         = p_q;
    g_d         = g_q;
    gp_d        = gp_q;
    gg_d        = gg_q;
    c0_d        = c0_q;
    s1_valid_d  = s1_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    if (en) begin
      p_d         = p_s1;
      g_d         = g_s1;
      gp_d        = gp_s1;
      gg_d        = gg_s1;
      c0_d        = sub ? 1'b1 : cin;
      s1_valid_d  = in_valid;
      sum_d       = sum_s2;
      cout_d      = c_grp[NG];
      overflow_d  = c_msb_in ^ c_grp[NG];
      out_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q         <= '0;
      g_q         <= '0;
      gp_q        <= '0;
      gg_q        <= '0;
      c0_q        <= 1'b0;
      s1_valid_q  <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      g_q         <= g_d;
      gp_q        <= gp_d;
      gg_q        <= gg_d;
      c0_q        <= c0_d;
      s1_valid_q  <= s1_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule
